// File: rtl/trace_pkg.sv
// Shared types for the commit trace buffer: record layout, capture states and
// the ebreak encoding used for program-end detection.
package trace_pkg;

  localparam int unsigned TRACE_XLEN = 32;
  localparam logic [31:0] EBREAK_INSN = 32'h0010_0073;

  typedef struct packed {
    logic [TRACE_XLEN-1:0] pc;
    logic [31:0]           instr;
    logic                  mem_we;
    logic [TRACE_XLEN-1:0] addr;
    logic [TRACE_XLEN-1:0] wdata;
  } trace_rec_t;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } trace_state_t;

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Retire-side commit bus plus the valid/ready drain port of the trace buffer.
interface commit_trace_buffer_if #(
  parameter int XLEN = 32
);
  logic            commit_valid;
  logic [XLEN-1:0] commit_pc;
  logic [XLEN-1:0] commit_pc_next;
  logic [31:0]     commit_instr;
  logic            commit_mem_we;
  logic [XLEN-1:0] commit_addr;
  logic [XLEN-1:0] commit_wdata;

  logic            rd_valid;
  logic            rd_ready;
  logic [XLEN-1:0] rd_pc;
  logic [31:0]     rd_instr;
  logic            rd_mem_we;
  logic [XLEN-1:0] rd_addr;
  logic [XLEN-1:0] rd_wdata;

  modport master (
    output commit_valid, commit_pc, commit_pc_next, commit_instr,
           commit_mem_we, commit_addr, commit_wdata, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_mem_we, rd_addr, rd_wdata
  );

  modport slave (
    input  commit_valid, commit_pc, commit_pc_next, commit_instr,
           commit_mem_we, commit_addr, commit_wdata, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_mem_we, rd_addr, rd_wdata
  );
endinterface

// File: rtl/trace_fifo.sv
// DEPTH-deep synchronous FIFO of trace records with wrap-bit pointers and a
// synchronous flush that overrides push and pop.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  trace_rec_t             push_data,
  input  logic                   pop,
  output trace_rec_t             head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0] wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0] rd_ptr_q, rd_ptr_d;
  logic           do_push, do_pop;
  trace_rec_t     mem_q [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                 (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign head  = mem_q[rd_ptr_q[IDX_W-1:0]];

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  always_comb begin
    do_pop   = pop && !empty && !flush;
    do_push  = push && (!full || do_pop) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[IDX_W-1:0]] <= push_data;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Commit-trace capture: records retired instructions into a drainable FIFO,
// detects program end and keeps statistics. TRACE_MEM_ONLY_EN records stores only.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN        = TRACE_XLEN,
  parameter int DEPTH       = 16,
  parameter int HALT_REPEAT = 4,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  commit_trace_buffer_if.slave   bus,
  output logic [$clog2(DEPTH):0] level,
  output logic                   halted,
  output logic                   halt_cause,
  output logic                   overflow,
  output logic [CNT_W-1:0]       drop_count,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       retire_count
);

  localparam int LOOP_W = $clog2(HALT_REPEAT + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  trace_state_t      state_q, state_d;
  logic [LOOP_W-1:0] loop_cnt_q, loop_cnt_d, loop_inc;
  logic              halt_cause_q, halt_cause_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  retire_q, retire_d;

  logic [XLEN-1:0]   pc_w, pc_next_w;
  logic              want_push, push_req, pop_req, rd_valid;
  logic              fifo_full, fifo_empty;
  trace_rec_t        rec, head;

  assign pc_w      = bus.commit_pc;
  assign pc_next_w = bus.commit_pc_next;
  assign loop_inc  = loop_cnt_q + LOOP_W'(1);

  assign rec.pc     = bus.commit_pc;
  assign rec.instr  = bus.commit_instr;
  assign rec.mem_we = bus.commit_mem_we;
  assign rec.addr   = bus.commit_addr;
  assign rec.wdata  = bus.commit_wdata;

`ifdef TRACE_MEM_ONLY_EN
  assign want_push = bus.commit_mem_we;
`else
  assign want_push = 1'b1;
`endif

  assign rd_valid = !fifo_empty;
  assign pop_req  = rd_valid && bus.rd_ready;

  always_comb begin
    state_d      = state_q;
    loop_cnt_d   = loop_cnt_q;
    halt_cause_d = halt_cause_q;
    overflow_d   = overflow_q;
    drop_d       = drop_q;
    cycle_d      = cycle_q;
    retire_d     = retire_q;
    push_req     = 1'b0;
    if (clear) begin
      state_d      = RUN;
      loop_cnt_d   = '0;
      halt_cause_d = 1'b0;
      overflow_d   = 1'b0;
      drop_d       = '0;
      cycle_d      = '0;
      retire_d     = '0;
    end else if (state_q == RUN) begin
      cycle_d = sat_inc(cycle_q);
      if (bus.commit_valid) begin
        retire_d = sat_inc(retire_q);
        push_req = want_push;
        if (want_push && fifo_full && !pop_req) begin
          overflow_d = 1'b1;
          drop_d     = sat_inc(drop_q);
        end
        // ebreak wins over the self-loop count; the halting commit itself is still recorded.
        if (bus.commit_instr == EBREAK_INSN) begin
          state_d      = HALTED;
          halt_cause_d = 1'b1;
        end else if (pc_next_w == pc_w) begin
          loop_cnt_d = loop_inc;
          if (loop_inc == LOOP_W'(HALT_REPEAT)) begin
            state_d      = HALTED;
            halt_cause_d = 1'b0;
          end
        end else begin
          loop_cnt_d = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= RUN;
      loop_cnt_q   <= '0;
      halt_cause_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
      cycle_q      <= '0;
      retire_q     <= '0;
    end else begin
      state_q      <= state_d;
      loop_cnt_q   <= loop_cnt_d;
      halt_cause_q <= halt_cause_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
      cycle_q      <= cycle_d;
      retire_q     <= retire_d;
    end
  end

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clear),
    .push      (push_req),
    .push_data (rec),
    .pop       (pop_req),
    .head      (head),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.rd_valid  = rd_valid;
  assign bus.rd_pc     = head.pc;
  assign bus.rd_instr  = head.instr;
  assign bus.rd_mem_we = head.mem_we;
  assign bus.rd_addr   = head.addr;
  assign bus.rd_wdata  = head.wdata;

  assign halted       = (state_q == HALTED);
  assign halt_cause   = halt_cause_q;
  assign overflow     = overflow_q;
  assign drop_count   = drop_q;
  assign cycle_count  = cycle_q;
  assign retire_count = retire_q;

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
Synthesizable commit-trace capture block for the RISC-V core. It records retired instructions (pc, instr, store info) into a parametrised FIFO that the bench or a debug port drains with a valid/ready handshake. It detects program end (ebreak or a PC self-loop) and maintains cycle, retire and drop counters. It replaces ad-hoc waveform inspection of the top-level debug outputs with a checkable, drainable stream.

Parameters:
XLEN, 32, datapath width of pc/addr/wdata
DEPTH, 16, FIFO entries; power of 2, >= 2
HALT_REPEAT, 4, consecutive self-loop commits (pc_next == pc) that declare a halt; >= 1
CNT_W, 32, width of the statistics counters

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset
clear  in  1  synchronous flush/restart
commit_valid  in  1  an instruction retires this cycle
commit_pc  in  XLEN  pc of retiring instruction
commit_pc_next  in  XLEN  next pc chosen by the retiring instruction
commit_instr  in  32  instruction word
commit_mem_we  in  1  instruction is a store
commit_addr  in  XLEN  ALU result / store address
commit_wdata  in  XLEN  store data
rd_valid  out  1  head entry available
rd_ready  in  1  consumer accepts the head entry
rd_pc, rd_instr, rd_mem_we, rd_addr, rd_wdata  out  XLEN/32/1/XLEN/XLEN  head-entry fields
level  out  $clog2(DEPTH)+1  current occupancy
halted  out  1  capture stopped
halt_cause  out  1  0 = self-loop, 1 = ebreak
overflow  out  1  sticky: at least one commit dropped
drop_count, cycle_count, retire_count  out  CNT_W each  statistics

Behaviour:
- Reset (rst low, async): FIFO empty, level=0, rd_valid=0, halted=0, halt_cause=0, overflow=0, all counters 0, loop counter 0, FSM=RUN. rd_* data is don't-care while rd_valid=0.
- Push: commit_valid && FSM==RUN. Entry written at the clock edge. rd_valid rises the following cycle, so latency is 1.
- Pop: rd_valid && rd_ready. Head advances at the clock edge. rd_* is driven combinationally from the head slot.
- Full and push without pop: the entry is dropped, overflow set (sticky), drop_count += 1. The FIFO contents are unchanged.
- Full with push and pop in the same cycle: both are accepted; level stays at DEPTH; no drop.
- Empty with push and pop in the same cycle: the pop is ignored, because rd_valid=0.
- Pointers are $clog2(DEPTH) bits plus a wrap bit. Full = indices equal and wrap bits differ.
- retire_count += 1 on every commit_valid in RUN, whether pushed or dropped.
- cycle_count += 1 every cycle in RUN.
- All counters saturate at all-ones.
- FSM RUN:
  - commit_valid with instr == 32'h00100073 (ebreak): the entry is pushed normally, then HALTED next cycle, halt_cause=1.
  - Otherwise, commit_valid with pc_next == pc increments loop_cnt. Any commit with pc_next != pc clears loop_cnt. Idle cycles (commit_valid=0) leave loop_cnt unchanged.
  - The HALT_REPEAT-th consecutive self-loop commit is pushed, then HALTED, halt_cause=0.
  - ebreak takes priority over the self-loop check.
- FSM HALTED: no pushes, cycle_count and retire_count frozen, popping continues until empty. Leaves HALTED only on clear or reset.
- clear: FIFO flushed, counters, overflow and loop_cnt zeroed, halted=0, FSM=RUN. Clear takes priority over any push or pop in the same cycle; that commit is not recorded.
- Reset mid-drain: state returns to reset values immediately, asynchronously. Deassertion takes effect at the next clock edge.

Optional Feature:
TRACE_MEM_ONLY_EN
- Defined: only commits with commit_mem_we=1 are pushed. A non-store commit does not push, does not drop and does not touch overflow. retire_count, halt detection and ebreak still apply to all commits. An ebreak is not pushed unless it is a store, which cannot occur.
- Undefined: every commit in RUN is pushed, as described above.

Decomposition:
- Shared package trace_pkg:
  - EBREAK_INSN = 32'h00100073
  - typedef trace_rec_t {pc, instr, mem_we, addr, wdata}
  - enum trace_state_t {RUN, HALTED}
- One sub-module, trace_fifo. It is a generic DEPTH-deep synchronous FIFO of trace_rec_t, providing push/pop, level, full/empty and flush, and uses the same async active-low rst.
- The top block holds the FSM, loop counter, statistics counters and the optional filter.

Test Plan:
- Push pc 0x00,0x04,...,0x3C (16 commits) with rd_ready=0 -> level=16, overflow=0. Then drain -> 16 entries in order, level=0.
- DEPTH=16, 20 commits with rd_ready=0 -> level=16, overflow=1, drop_count=4, retire_count=20, first 16 entries intact.
- FIFO full, commit_valid=1 and rd_ready=1 for 5 cycles -> level stays 16, drop_count=0, popped pcs appear in push order.
- Commit instr 0x00100073 at pc 0x40 -> entry 0x40 recorded, halted=1 and halt_cause=1 next cycle. Further commits ignored; retire_count frozen.
- HALT_REPEAT=4: self-loop commits at pc 0x80 x3, one commit 0x80->0x84, then 0x84 self-loop x4 -> halts only after the 4th 0x84 commit, halt_cause=0. Then assert clear -> all counters 0, level=0, halted=0.
- Assert rst low mid-drain with level=7 -> rd_valid=0 and level=0 immediately, without waiting for a clock. After release, a new commit is captured normally.
